// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// instruction_decode : registered RV32I decoder, one-hot op groups + fields.
// Optional build macro DECODE_STRICT_EN enables reserved-field checking.
// Revision: 1.0
// ============================================================================
module instruction_decode (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction_code,
   input  logic        en,
   output logic [31:0] invalid_instruction,
   output logic [18:0] alu_op,
   output logic [8:0]  jmp_op,
   output logic [8:0]  mem_op,
   output logic        cust_op,
   output logic [5:0]  csr_op,
   output logic [7:0]  mechie_op,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [6:0]  imm_2531,
   output logic [19:0] imm_1231,
   output logic [11:0] imm_2032
);

   localparam logic [6:0] c_op_lui    = 7'h37;
   localparam logic [6:0] c_op_auipc  = 7'h17;
   localparam logic [6:0] c_op_jal    = 7'h6F;
   localparam logic [6:0] c_op_jalr   = 7'h67;
   localparam logic [6:0] c_op_branch = 7'h63;
   localparam logic [6:0] c_op_load   = 7'h03;
   localparam logic [6:0] c_op_store  = 7'h23;
   localparam logic [6:0] c_op_imm    = 7'h13;
   localparam logic [6:0] c_op_reg    = 7'h33;
   localparam logic [6:0] c_op_fence  = 7'h0F;
   localparam logic [6:0] c_op_system = 7'h73;
   localparam logic [6:0] c_op_cust0  = 7'h0B;
   localparam logic [6:0] c_op_cust1  = 7'h7F;

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic        w_alt;
   logic [11:0] w_sys_imm;

   assign w_opcode  = instruction_code[6:0];
   assign w_funct3  = instruction_code[14:12];
   assign w_alt     = instruction_code[30];
   assign w_sys_imm = instruction_code[31:20];

   // Qualifiers for reserved fields; all pass when strict checking is off.
   logic w_f7_std_ok;
   logic w_f7_alt_ok;
   logic w_sys_ok;
   logic w_low_ok;

`ifdef DECODE_STRICT_EN
   logic [6:0] w_funct7;
   assign w_funct7    = instruction_code[31:25];
   assign w_f7_std_ok = (w_funct7 == 7'h00);
   assign w_f7_alt_ok = (w_funct7 == 7'h20);
   assign w_sys_ok    = (instruction_code[19:15] == 5'd0) && (instruction_code[11:7] == 5'd0);
   assign w_low_ok    = (w_opcode[1:0] == 2'b11);
`else
   assign w_f7_std_ok = 1'b1;
   assign w_f7_alt_ok = 1'b1;
   assign w_sys_ok    = 1'b1;
   assign w_low_ok    = 1'b1;
`endif

   logic [18:0] w_alu_op;
   logic [8:0]  w_jmp_op;
   logic [8:0]  w_mem_op;
   logic        w_cust_op;
   logic [5:0]  w_csr_op;
   logic [7:0]  w_mechie_op;
   logic        w_valid;

   always_comb begin
      w_alu_op    = '0;
      w_jmp_op    = '0;
      w_mem_op    = '0;
      w_cust_op   = 1'b0;
      w_csr_op    = '0;
      w_mechie_op = '0;
      if (w_low_ok) begin
         case (w_opcode)
            c_op_lui:   w_mem_op[8] = 1'b1;
            c_op_auipc: w_jmp_op[8] = 1'b1;
            c_op_jal:   w_jmp_op[0] = 1'b1;
            c_op_jalr:  w_jmp_op[1] = (w_funct3 == 3'b000);
            c_op_branch: begin
               case (w_funct3)
                  3'b000:  w_jmp_op[2] = 1'b1;
                  3'b001:  w_jmp_op[3] = 1'b1;
                  3'b100:  w_jmp_op[4] = 1'b1;
                  3'b101:  w_jmp_op[5] = 1'b1;
                  3'b110:  w_jmp_op[6] = 1'b1;
                  3'b111:  w_jmp_op[7] = 1'b1;
                  default: ;
               endcase
            end
            c_op_load: begin
               case (w_funct3)
                  3'b000:  w_mem_op[0] = 1'b1;
                  3'b001:  w_mem_op[1] = 1'b1;
                  3'b010:  w_mem_op[2] = 1'b1;
                  3'b100:  w_mem_op[3] = 1'b1;
                  3'b101:  w_mem_op[4] = 1'b1;
                  default: ;
               endcase
            end
            c_op_store: begin
               case (w_funct3)
                  3'b000:  w_mem_op[5] = 1'b1;
                  3'b001:  w_mem_op[6] = 1'b1;
                  3'b010:  w_mem_op[7] = 1'b1;
                  default: ;
               endcase
            end
            c_op_imm: begin
               case (w_funct3)
                  3'b000: w_alu_op[10] = 1'b1;
                  3'b010: w_alu_op[11] = 1'b1;
                  3'b011: w_alu_op[12] = 1'b1;
                  3'b100: w_alu_op[13] = 1'b1;
                  3'b110: w_alu_op[14] = 1'b1;
                  3'b111: w_alu_op[15] = 1'b1;
                  3'b001: w_alu_op[16] = w_f7_std_ok;
                  3'b101: begin
                     // Bit 30 splits arithmetic from logical right shift.
                     if (w_alt) w_alu_op[18] = w_f7_alt_ok;
                     else       w_alu_op[17] = w_f7_std_ok;
                  end
                  default: ;
               endcase
            end
            c_op_reg: begin
               case (w_funct3)
                  3'b000: begin
                     if (w_alt) w_alu_op[1] = w_f7_alt_ok;
                     else       w_alu_op[0] = w_f7_std_ok;
                  end
                  3'b001: w_alu_op[2] = w_f7_std_ok;
                  3'b010: w_alu_op[3] = w_f7_std_ok;
                  3'b011: w_alu_op[4] = w_f7_std_ok;
                  3'b100: w_alu_op[5] = w_f7_std_ok;
                  3'b101: begin
                     if (w_alt) w_alu_op[7] = w_f7_alt_ok;
                     else       w_alu_op[6] = w_f7_std_ok;
                  end
                  3'b110: w_alu_op[8] = w_f7_std_ok;
                  3'b111: w_alu_op[9] = w_f7_std_ok;
                  default: ;
               endcase
            end
            c_op_fence: begin
               case (w_funct3)
                  3'b000:  w_mechie_op[6] = 1'b1;
                  3'b001:  w_mechie_op[7] = 1'b1;
                  default: ;
               endcase
            end
            c_op_system: begin
               case (w_funct3)
                  3'b000: begin
                     if (w_sys_ok) begin
                        case (w_sys_imm)
                           12'h000: w_mechie_op[0] = 1'b1;
                           12'h001: w_mechie_op[1] = 1'b1;
                           12'h002: w_mechie_op[2] = 1'b1;
                           12'h102: w_mechie_op[3] = 1'b1;
                           12'h302: w_mechie_op[4] = 1'b1;
                           12'h105: w_mechie_op[5] = 1'b1;
                           default: ;
                        endcase
                     end
                  end
                  3'b001:  w_csr_op[0] = 1'b1;
                  3'b010:  w_csr_op[1] = 1'b1;
                  3'b011:  w_csr_op[2] = 1'b1;
                  3'b101:  w_csr_op[3] = 1'b1;
                  3'b110:  w_csr_op[4] = 1'b1;
                  3'b111:  w_csr_op[5] = 1'b1;
                  default: ;
               endcase
            end
            c_op_cust0, c_op_cust1: w_cust_op = 1'b1;
            default: ;
         endcase
      end
   end

   assign w_valid = (|w_alu_op) | (|w_jmp_op) | (|w_mem_op) | w_cust_op
                  | (|w_csr_op) | (|w_mechie_op);

   // Fields hold across en=0 so downstream can still read the last operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         invalid_instruction <= '0;
         alu_op              <= '0;
         jmp_op              <= '0;
         mem_op              <= '0;
         cust_op             <= 1'b0;
         csr_op              <= '0;
         mechie_op           <= '0;
         rd                  <= '0;
         rs1                 <= '0;
         rs2                 <= '0;
         imm_2531            <= '0;
         imm_1231            <= '0;
         imm_2032            <= '0;
      end else if (en) begin
         invalid_instruction <= w_valid ? 32'd0 : instruction_code;
         alu_op              <= w_alu_op;
         jmp_op              <= w_jmp_op;
         mem_op              <= w_mem_op;
         cust_op             <= w_cust_op;
         csr_op              <= w_csr_op;
         mechie_op           <= w_mechie_op;
         rd                  <= instruction_code[11:7];
         rs1                 <= instruction_code[19:15];
         rs2                 <= instruction_code[24:20];
         imm_2531            <= instruction_code[31:25];
         imm_1231            <= instruction_code[31:12];
         imm_2032            <= instruction_code[31:20];
      end else begin
         invalid_instruction <= '0;
         alu_op              <= '0;
         jmp_op              <= '0;
         mem_op              <= '0;
         cust_op             <= 1'b0;
         csr_op              <= '0;
         mechie_op           <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
// tb_instruction_decode : directed-vector bench for instruction_decode.
// Revision: 1.0
// ============================================================================
module tb_instruction_decode;

   logic        clk;
   logic        rst;
   logic [31:0] instruction_code;
   logic        en;
   logic [31:0] invalid_instruction;
   logic [18:0] alu_op;
   logic [8:0]  jmp_op;
   logic [8:0]  mem_op;
   logic        cust_op;
   logic [5:0]  csr_op;
   logic [7:0]  mechie_op;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  imm_2531;
   logic [19:0] imm_1231;
   logic [11:0] imm_2032;

   int n_checks = 0;
   int n_errors = 0;

   instruction_decode u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .instruction_code    (instruction_code),
      .en                  (en),
      .invalid_instruction (invalid_instruction),
      .alu_op              (alu_op),
      .jmp_op              (jmp_op),
      .mem_op              (mem_op),
      .cust_op             (cust_op),
      .csr_op              (csr_op),
      .mechie_op           (mechie_op),
      .rd                  (rd),
      .rs1                 (rs1),
      .rs2                 (rs2),
      .imm_2531            (imm_2531),
      .imm_1231            (imm_1231),
      .imm_2032            (imm_2032)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic expect_ops(input string tag, input logic [18:0] a, input logic [8:0] j,
                             input logic [8:0] m, input logic c, input logic [5:0] s,
                             input logic [7:0] me, input logic [31:0] inv);
      check_value({tag, "/alu"},  {13'd0, alu_op},    {13'd0, a});
      check_value({tag, "/jmp"},  {23'd0, jmp_op},    {23'd0, j});
      check_value({tag, "/mem"},  {23'd0, mem_op},    {23'd0, m});
      check_value({tag, "/cust"}, {31'd0, cust_op},   {31'd0, c});
      check_value({tag, "/csr"},  {26'd0, csr_op},    {26'd0, s});
      check_value({tag, "/mech"}, {24'd0, mechie_op}, {24'd0, me});
      check_value({tag, "/inv"},  invalid_instruction, inv);
   endtask

   task automatic expect_fields(input string tag, input logic [4:0] e_rd, input logic [4:0] e_rs1,
                                input logic [4:0] e_rs2, input logic [6:0] e_2531,
                                input logic [19:0] e_1231, input logic [11:0] e_2032);
      check_value({tag, "/rd"},   {27'd0, rd},       {27'd0, e_rd});
      check_value({tag, "/rs1"},  {27'd0, rs1},      {27'd0, e_rs1});
      check_value({tag, "/rs2"},  {27'd0, rs2},      {27'd0, e_rs2});
      check_value({tag, "/i2531"}, {25'd0, imm_2531}, {25'd0, e_2531});
      check_value({tag, "/i1231"}, {12'd0, imm_1231}, {12'd0, e_1231});
      check_value({tag, "/i2032"}, {20'd0, imm_2032}, {20'd0, e_2032});
   endtask

   task automatic drive(input logic [31:0] word, input logic e);
      @(negedge clk);
      instruction_code = word;
      en               = e;
      @(posedge clk);
      #1;
   endtask

   localparam logic [18:0] A = 19'd1;
   localparam logic [8:0]  J = 9'd1;
   localparam logic [8:0]  M = 9'd1;
   localparam logic [5:0]  S = 6'd1;
   localparam logic [7:0]  E = 8'd1;

   initial begin
      rst = 1'b1;
      en = 1'b0;
      instruction_code = 32'h0;
      repeat (2) @(negedge clk);
      expect_ops("reset", 0, 0, 0, 0, 0, 0, 32'h0);
      expect_fields("reset", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      drive(32'h02C78793, 1'b1);
      expect_ops("pre_rst_addi", A << 10, 0, 0, 0, 0, 0, 32'h0);
      #2 rst = 1'b1;
      #1;
      expect_ops("async_rst", 0, 0, 0, 0, 0, 0, 32'h0);
      expect_fields("async_rst", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      drive(32'h00000000, 1'b1);
      expect_ops("zero_word", 0, 0, 0, 0, 0, 0, 32'h0);
      drive(32'h00000057, 1'b1);
      expect_ops("bad_opcode", 0, 0, 0, 0, 0, 0, 32'h00000057);

      drive(32'h00000797, 1'b1);
      expect_ops("auipc", 0, J << 8, 0, 0, 0, 0, 32'h0);
      check_value("auipc/rd", {27'd0, rd}, 32'd15);
      check_value("auipc/i1231", {12'd0, imm_1231}, 32'd0);

      drive(32'h02C78793, 1'b1);
      expect_ops("addi", A << 10, 0, 0, 0, 0, 0, 32'h0);
      expect_fields("addi", 15, 15, 5'h0C, 7'h01, 20'h02C78, 12'h02C);

      drive(32'h07F56513, 1'b1);
      expect_ops("ori", A << 14, 0, 0, 0, 0, 0, 32'h0);
      check_value("ori/rd", {27'd0, rd}, 32'd10);
      check_value("ori/rs1", {27'd0, rs1}, 32'd10);
      check_value("ori/i2032", {20'd0, imm_2032}, 32'h07F);

      drive(32'h305793F3, 1'b1);
      expect_ops("csrrw", 0, 0, 0, 0, S << 0, 0, 32'h0);
      check_value("csrrw/rd", {27'd0, rd}, 32'd7);
      check_value("csrrw/rs1", {27'd0, rs1}, 32'd15);
      check_value("csrrw/i2032", {20'd0, imm_2032}, 32'h305);

      drive(32'h30200073, 1'b1);
      expect_ops("mret", 0, 0, 0, 0, 0, E << 4, 32'h0);
      drive(32'h00000073, 1'b1);
      expect_ops("ecall", 0, 0, 0, 0, 0, E << 0, 32'h0);
      drive(32'h00100073, 1'b1);
      expect_ops("ebreak", 0, 0, 0, 0, 0, E << 1, 32'h0);
      drive(32'h10500073, 1'b1);
      expect_ops("wfi", 0, 0, 0, 0, 0, E << 5, 32'h0);
      drive(32'h00300073, 1'b1);
      expect_ops("bad_sysimm", 0, 0, 0, 0, 0, 0, 32'h00300073);
      drive(32'h00004073, 1'b1);
      expect_ops("sys_f3_4", 0, 0, 0, 0, 0, 0, 32'h00004073);

      drive(32'h1A5000EF, 1'b1);
      expect_ops("jal", 0, J << 0, 0, 0, 0, 0, 32'h0);
      check_value("jal/rd", {27'd0, rd}, 32'd1);
      check_value("jal/i1231", {12'd0, imm_1231}, 32'h1A500);

      // Next word is on the input before the edge: output must still be jal.
      @(negedge clk);
      instruction_code = 32'h04079263;
      en = 1'b1;
      #1;
      check_value("latency_hold", {23'd0, jmp_op}, {23'd0, J << 0});
      @(posedge clk);
      #1;
      expect_ops("bne", 0, J << 3, 0, 0, 0, 0, 32'h0);
      check_value("bne/rs1", {27'd0, rs1}, 32'd15);
      check_value("bne/rs2", {27'd0, rs2}, 32'd0);
      check_value("bne/i2531", {25'd0, imm_2531}, 32'h02);

      drive(32'h00002063, 1'b1);
      expect_ops("branch_f3_2", 0, 0, 0, 0, 0, 0, 32'h00002063);

      drive(32'h40B50533, 1'b1);
      expect_ops("sub", A << 1, 0, 0, 0, 0, 0, 32'h0);
      drive(32'h00B50533, 1'b1);
      expect_ops("add", A << 0, 0, 0, 0, 0, 0, 32'h0);
      drive(32'h4010D093, 1'b1);
      expect_ops("srai", A << 18, 0, 0, 0, 0, 0, 32'h0);
      drive(32'h0010D093, 1'b1);
      expect_ops("srli", A << 17, 0, 0, 0, 0, 0, 32'h0);
      drive(32'h0000C503, 1'b1);
      expect_ops("lbu", 0, 0, M << 3, 0, 0, 0, 32'h0);
      drive(32'h0000100F, 1'b1);
      expect_ops("fence_i", 0, 0, 0, 0, 0, E << 7, 32'h0);
      drive(32'h12345537, 1'b1);
      expect_ops("lui", 0, 0, M << 8, 0, 0, 0, 32'h0);

      drive(32'h8000007F, 1'b1);
      expect_ops("cust7f", 0, 0, 0, 1'b1, 0, 0, 32'h0);
      drive(32'h0000000B, 1'b1);
      expect_ops("cust0b", 0, 0, 0, 1'b1, 0, 0, 32'h0);

      drive(32'h00112623, 1'b1);
      expect_ops("sw", 0, 0, M << 7, 0, 0, 0, 32'h0);
      expect_fields("sw", 12, 2, 1, 7'h00, 20'h00112, 12'h001);

      drive(32'h07F56513, 1'b0);
      expect_ops("en_low", 0, 0, 0, 0, 0, 0, 32'h0);
      expect_fields("en_low", 12, 2, 1, 7'h00, 20'h00112, 12'h001);
      drive(32'h00000057, 1'b0);
      expect_ops("en_low_bad", 0, 0, 0, 0, 0, 0, 32'h0);

      drive(32'h07F56513, 1'b1);
      expect_ops("en_back", A << 14, 0, 0, 0, 0, 0, 32'h0);
      check_value("en_back/rd", {27'd0, rd}, 32'd10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
